// File: rtl/ucsbece152a_prog_counter.sv
// Up/down counter with programmable terminal value, wrap/saturate/one-shot modes,
// and a registered boundary pulse. Define UCSBECE152A_COUNTER_PRESCALE_EN to step once per PRESCALE enabled cycles.
module ucsbece152a_prog_counter #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable_i,
   input  logic             dir_i,
   input  logic [1:0]       mode_i,
   input  logic [WIDTH-1:0] max_i,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic [WIDTH-1:0] count_o,
   output logic             tc_o,
   output logic             done_o,
   output logic             at_max_o,
   output logic             at_zero_o
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state_r;
   logic [WIDTH-1:0] count_r;
   logic             tc_r;
   logic             done_r;
   logic             tick_s;
   logic             step_s;
   logic             boundary_s;
   logic [WIDTH-1:0] next_count_s;
   logic [WIDTH-1:0] load_sat_s;

`ifdef UCSBECE152A_COUNTER_PRESCALE_EN
   localparam int               DIV_W    = $clog2(PRESCALE) + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PRESCALE - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   logic [DIV_W-1:0] div_r;

   assign tick_s = (div_r == DIV_LAST);

   // Prescale divider: advances only on enabled RUN cycles, restarts on clear/load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_r <= '0;
      end else if (clear_i || load_i) begin
         div_r <= '0;
      end else if (enable_i && (state_r == ST_RUN)) begin
         div_r <= tick_s ? '0 : (div_r + DIV_ONE);
      end else begin
         div_r <= div_r;
      end
   end
`else
   assign tick_s = 1'b1;
`endif

   assign step_s     = enable_i && (state_r == ST_RUN) && tick_s;
   assign load_sat_s = (load_val_i > max_i) ? max_i : load_val_i;

   // Next count on a step; ">=" lets a lowered max_i still count as the upper boundary.
   always_comb begin
      next_count_s = count_r;
      boundary_s   = 1'b0;
      if (dir_i) begin
         boundary_s = (count_r == '0);
      end else begin
         boundary_s = (count_r >= max_i);
      end
      if (!boundary_s) begin
         next_count_s = dir_i ? (count_r - ONE) : (count_r + ONE);
      end else begin
         case (mode_i)
            2'b01:   next_count_s = count_r;
            2'b10:   next_count_s = count_r;
            default: next_count_s = dir_i ? max_i : '0;
         endcase
      end
   end

   // Count, pulse and one-shot FSM; clear beats load beats step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= '0;
         tc_r    <= 1'b0;
         done_r  <= 1'b0;
         state_r <= ST_RUN;
      end else if (clear_i) begin
         count_r <= '0;
         tc_r    <= 1'b0;
         done_r  <= 1'b0;
         state_r <= ST_RUN;
      end else if (load_i) begin
         count_r <= load_sat_s;
         tc_r    <= 1'b0;
         done_r  <= 1'b0;
         state_r <= ST_RUN;
      end else if (step_s) begin
         count_r <= next_count_s;
         tc_r    <= boundary_s;
         if (boundary_s && (mode_i == 2'b10)) begin
            state_r <= ST_HALT;
            done_r  <= 1'b1;
         end else begin
            state_r <= state_r;
            done_r  <= done_r;
         end
      end else begin
         count_r <= count_r;
         tc_r    <= 1'b0;
         done_r  <= done_r;
         state_r <= state_r;
      end
   end

   assign count_o   = count_r;
   assign tc_o      = tc_r;
   assign done_o    = done_r;
   assign at_max_o  = (count_r >= max_i);
   assign at_zero_o = (count_r == '0);

endmodule

// File: tb/tb_ucsbece152a_prog_counter.sv
// Directed-vector bench for ucsbece152a_prog_counter (WIDTH=4, PRESCALE=4).
module tb_ucsbece152a_prog_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable_i;
   logic       dir_i;
   logic [1:0] mode_i;
   logic [3:0] max_i;
   logic       clear_i;
   logic       load_i;
   logic [3:0] load_val_i;
   logic [3:0] count_o;
   logic       tc_o;
   logic       done_o;
   logic       at_max_o;
   logic       at_zero_o;

   int tests_run = 0;
   int tests_failed = 0;

   ucsbece152a_prog_counter #(.WIDTH(4), .PRESCALE(4)) dut (
      .clk(clk), .rst(rst), .enable_i(enable_i), .dir_i(dir_i), .mode_i(mode_i),
      .max_i(max_i), .clear_i(clear_i), .load_i(load_i), .load_val_i(load_val_i),
      .count_o(count_o), .tc_o(tc_o), .done_o(done_o),
      .at_max_o(at_max_o), .at_zero_o(at_zero_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; enable_i = 1'b0; dir_i = 1'b0; mode_i = 2'b00; max_i = 4'd9;
      clear_i = 1'b0; load_i = 1'b0; load_val_i = 4'd0;
      tick();
      tick();
      check_eq("rst_count", count_o, 0);
      check_eq("rst_tc", tc_o, 0);
      check_eq("rst_done", done_o, 0);
      check_eq("rst_at_zero", at_zero_o, 1);
      rst = 1'b0;

`ifdef UCSBECE152A_COUNTER_PRESCALE_EN
      max_i = 4'd15; enable_i = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         check_eq($sformatf("ps_count_%0d", i), count_o, i / 4);
      end
      tick(); check_eq("ps_a1", count_o, 3);
      tick(); check_eq("ps_a2", count_o, 3);
      enable_i = 1'b0;
      tick(); check_eq("ps_hold1", count_o, 3);
      tick(); check_eq("ps_hold2", count_o, 3);
      enable_i = 1'b1;
      tick(); check_eq("ps_b1", count_o, 3);
      tick(); check_eq("ps_b2", count_o, 4);
`else
      // Wrap up 0..9
      enable_i = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         check_eq($sformatf("wrap_up_count_%0d", i), count_o, i % 10);
         check_eq($sformatf("wrap_up_tc_%0d", i), tc_o, (i == 10) ? 1 : 0);
      end

      // Wrap down from 0 with max 5
      enable_i = 1'b0; clear_i = 1'b1;
      tick();
      check_eq("clear_count", count_o, 0);
      clear_i = 1'b0; max_i = 4'd5; dir_i = 1'b1; enable_i = 1'b1;
      tick(); check_eq("wrap_dn_c0", count_o, 5); check_eq("wrap_dn_tc0", tc_o, 1);
      tick(); check_eq("wrap_dn_c1", count_o, 4); check_eq("wrap_dn_tc1", tc_o, 0);
      tick(); check_eq("wrap_dn_c2", count_o, 3); check_eq("wrap_dn_tc2", tc_o, 0);

      // Saturate up at 7, then lower max below count
      enable_i = 1'b0; dir_i = 1'b0; mode_i = 2'b01; max_i = 4'd7;
      load_i = 1'b1; load_val_i = 4'd7;
      tick();
      load_i = 1'b0;
      check_eq("sat_load", count_o, 7);
      check_eq("sat_load_tc", tc_o, 0);
      enable_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq($sformatf("sat_count_%0d", i), count_o, 7);
         check_eq($sformatf("sat_tc_%0d", i), tc_o, 1);
      end
      enable_i = 1'b0; max_i = 4'd4;
      #1 check_eq("sat_at_max", at_max_o, 1);
      tick(); check_eq("sat_idle_tc", tc_o, 0);
      enable_i = 1'b1;
      tick(); check_eq("sat_low_count", count_o, 7); check_eq("sat_low_tc", tc_o, 1);

      // Load clamps to max
      enable_i = 1'b0; load_i = 1'b1; load_val_i = 4'd12;
      tick(); check_eq("load_clamp", count_o, 4);
      load_i = 1'b0;

      // One-shot down from 3
      max_i = 4'd7; mode_i = 2'b10; dir_i = 1'b1; load_i = 1'b1; load_val_i = 4'd3;
      tick(); load_i = 1'b0; check_eq("os_load", count_o, 3);
      enable_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check_eq($sformatf("os_count_%0d", i), count_o, (i < 3) ? (2 - i) : 0);
         check_eq($sformatf("os_done_%0d", i), done_o, (i >= 3) ? 1 : 0);
         check_eq($sformatf("os_tc_%0d", i), tc_o, (i == 3) ? 1 : 0);
      end
      dir_i = 1'b0; mode_i = 2'b00;
      tick(); check_eq("os_halt_count", count_o, 0); check_eq("os_halt_done", done_o, 1);
      tick(); check_eq("os_halt_tc", tc_o, 0);
      load_i = 1'b1; load_val_i = 4'd2; dir_i = 1'b1; mode_i = 2'b10;
      tick(); load_i = 1'b0;
      check_eq("os_reload_count", count_o, 2); check_eq("os_reload_done", done_o, 0);
      tick(); check_eq("os_resume", count_o, 1);

      // max_i = 0: every step is a boundary
      max_i = 4'd0; mode_i = 2'b00; dir_i = 1'b0; clear_i = 1'b1;
      tick(); clear_i = 1'b0;
      tick(); check_eq("max0_count_a", count_o, 0); check_eq("max0_tc_a", tc_o, 1);
      dir_i = 1'b1;
      tick(); check_eq("max0_count_b", count_o, 0); check_eq("max0_tc_b", tc_o, 1);

      // Priority clear > load > step
      max_i = 4'd9; dir_i = 1'b0; enable_i = 1'b0; load_i = 1'b1; load_val_i = 4'd6;
      tick(); check_eq("prio_pre", count_o, 6);
      clear_i = 1'b1; enable_i = 1'b1; load_val_i = 4'd3;
      tick(); clear_i = 1'b0; load_i = 1'b0; enable_i = 1'b0;
      check_eq("prio_count", count_o, 0); check_eq("prio_tc", tc_o, 0);

      // Async reset from a halted, pulsing state
      mode_i = 2'b10; load_i = 1'b1; load_val_i = 4'd9;
      tick(); load_i = 1'b0; enable_i = 1'b1;
      tick();
      check_eq("ar_pre_done", done_o, 1); check_eq("ar_pre_tc", tc_o, 1);
      #2 rst = 1'b1;
      #1;
      check_eq("ar_count", count_o, 0);
      check_eq("ar_tc", tc_o, 0);
      check_eq("ar_done", done_o, 0);
      tick(); rst = 1'b0; enable_i = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
